// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte queue written on each falling edge of rx_int.
// Define UART_RXF_DROP_OLD_EN to overwrite the oldest byte when a frame arrives while full.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_int,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   fill_cnt,
    output logic          full,
    output logic          overflow,
    input  logic          ovf_clr
);
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_rx_int_q, r_overflow;
    logic        w_wr, w_rd, w_full, w_ovf_evt, w_do_wr, w_do_rd;
    assign w_wr      = r_rx_int_q & ~rx_int;
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign fill_cnt  = r_wr_ptr - r_rd_ptr;
    assign dout_valid = fill_cnt != '0;
    assign w_rd      = dout_valid & dout_ready;
    assign w_ovf_evt = w_wr & w_full & ~w_rd;
`ifdef UART_RXF_DROP_OLD_EN
    // write slot equals the head slot when full, so the oldest byte is replaced in place
    assign w_do_wr = w_wr;
    assign w_do_rd = w_rd | w_ovf_evt;
`else
    assign w_do_wr = w_wr & ~w_ovf_evt;
    assign w_do_rd = w_rd;
`endif
    assign dout     = r_mem[r_rd_ptr[AW-1:0]];
    assign full     = w_full;
    assign overflow = r_overflow;
    always_ff @(posedge clk) begin
        if (rst_n && w_do_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rx_int_q <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rx_int_q <= rx_int;
            if (w_do_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_overflow <= w_ovf_evt ? 1'b1 : (ovf_clr ? 1'b0 : r_overflow);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_int = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          dout_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [7:0]    dout;
    logic          dout_valid, full, overflow;
    logic [AW:0]   fill_cnt;
    int            n_tests = 0;
    int            n_fail = 0;
    byte unsigned  q[$];
    byte unsigned  drained[$];
    byte unsigned  exp_seq[$];
    logic          m_prev = 1'b0;
    logic          m_ovf = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_int(rx_int),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fill_cnt(fill_cnt), .full(full), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic ri, input logic [7:0] d, input logic rdy, input logic clr);
        logic wr, rd, was_full, evt;
        wr       = m_prev & ~ri;
        rd       = (q.size() != 0) && rdy;
        was_full = q.size() == DEPTH;
        evt      = wr && was_full && !rd;
        if (rd) void'(q.pop_front());
        if (wr) begin
            if (q.size() < DEPTH) q.push_back(d);
`ifdef UART_RXF_DROP_OLD_EN
            else begin
                void'(q.pop_front());
                q.push_back(d);
            end
`endif
        end
        m_ovf  = evt ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_prev = ri;
    endtask

    task automatic compare_all();
        check("valid", dout_valid, q.size() != 0);
        check("fill", fill_cnt, q.size());
        check("full", full, q.size() == DEPTH);
        check("ovf", overflow, m_ovf);
        if (q.size() != 0) check("dout", dout, q[0]);
    endtask

    task automatic step(input logic ri, input logic [7:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        rx_int = ri; rx_data = d; dout_ready = rdy; ovf_clr = clr;
        #5;
        if (rst_n && dout_valid && rdy) drained.push_back(dout);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_prev = 1'b0;
            m_ovf  = 1'b0;
        end else model_edge(ri, d, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, b, rdy, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, drained.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < drained.size(); i++)
            check(tag, drained[i], exp_seq[i]);
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_valid", dout_valid, 0);
        check("rst_fill", fill_cnt, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;

        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'hA5, 1'b0, 1'b0);
        check("single_valid", dout_valid, 1);
        check("single_dout", dout, 8'hA5);
        check("single_fill", fill_cnt, 1);
        drain(1);

        drained.delete(); exp_seq.delete();
        for (int i = 0; i < 40; i++) begin
            send(8'(i), 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            exp_seq.push_back(8'(i));
        end
        check_seq("order");
        check("order_ovf", overflow, 0);

        drained.delete(); exp_seq.delete();
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0);
        check("fill_full", full, 1);
        check("fill_cnt16", fill_cnt, 16);
        send(8'hEE, 1'b0);
        check("fill_ovf", overflow, 1);
        drain(17);
`ifdef UART_RXF_DROP_OLD_EN
        for (int i = 1; i < 16; i++) exp_seq.push_back(8'h10 + 8'(i));
        exp_seq.push_back(8'hEE);
`else
        for (int i = 0; i < 16; i++) exp_seq.push_back(8'h10 + 8'(i));
`endif
        check_seq("fill_drain");
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_no_evt", overflow, 0);

        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h77, 1'b1, 1'b0);
        check("simul_fill", fill_cnt, 16);
        check("simul_ovf", overflow, 0);
        check("simul_head", dout, 8'h41);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h99, 1'b0, 1'b1);
        check("clr_vs_evt", overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_after", overflow, 0);

        drain(16);
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b0);
        check("pre_rst_fill", fill_cnt, 5);
        rst_n = 1'b0;
        step(1'b1, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_fill", fill_cnt, 0);
        check("mid_rst_ovf", overflow, 0);
        step(1'b0, 8'h55, 1'b0, 1'b0);
        check("post_rst_nowr", fill_cnt, 0);
        send(8'h3C, 1'b0);
        check("post_rst_dout", dout, 8'h3C);
        check("post_rst_fill", fill_cnt, 1);

        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct = (blk * 37) % 100;
            for (int i = 0; i < 500; i++) begin
                rst_n = ($urandom_range(0, 499) != 0);
                step(1'($urandom_range(0, 1)), 8'($urandom),
                     1'($urandom_range(0, 99) < rdy_pct), 1'($urandom_range(0, 19) == 0));
            end
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of byte entries; fixed power of two.
REQ-002 Parameter: AW, 4, pointer address width; log2(DEPTH).
REQ-003 Port: clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: rx_data  input  8  received byte from the UART receiver; stable while rx_int low.
REQ-006 Port: rx_int  input  1  receiver busy flag; high during a frame, falls when rx_data updates.
REQ-007 Port: dout  output  8  head-of-queue byte (first-word-fall-through).
REQ-008 Port: dout_valid  output  1  queue non-empty; dout meaningful.
REQ-009 Port: dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 Port: fill_cnt  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-011 Port: full  output  1  fill_cnt == DEPTH.
REQ-012 Port: overflow  output  1  sticky: a byte arrived while full.
REQ-013 Port: ovf_clr  input  1  one-cycle clear of overflow.

Function
REQ-014 Register rx_int into rx_int_q each cycle; write strobe wr = rx_int_q & ~rx_int (one-cycle pulse per frame).
REQ-015 On wr with space available, store rx_data at wr_ptr, advance wr_ptr by 1.
REQ-016 Write latency: wr in cycle N -> dout_valid high and dout = that byte from cycle N+1 (if queue was empty).
REQ-017 Read strobe rd = dout_valid & dout_ready; on rd advance rd_ptr by 1; dout_ready ignored while dout_valid low.
REQ-018 dout = mem[rd_ptr] combinationally; dout_valid = (fill_cnt != 0).
REQ-019 Pointers AW+1 bits wide, wrap modulo 2*DEPTH; full when addresses equal and MSBs differ, empty when fully equal.
REQ-020 fill_cnt: +1 on write only, -1 on read only, unchanged on simultaneous read+write.
REQ-021 wr and rd in same cycle while full: both performed, fill_cnt stays DEPTH, overflow not set.
REQ-022 wr and rd in same cycle while empty: rd impossible (valid low); write accepted.
REQ-023 wr while full and no rd: overflow event; handling per REQ-029/REQ-030; overflow <= 1.
REQ-024 ovf_clr clears overflow next cycle; overflow event in same cycle wins (overflow stays 1).
REQ-025 rx_int held high or held low produces no write; only a 1->0 transition writes.

Reset
REQ-026 While rst_n low at a rising edge: wr_ptr=0, rd_ptr=0, rx_int_q=0, overflow=0.
REQ-027 Reset outputs: dout_valid=0, fill_cnt=0, full=0, overflow=0; dout don't-care; memory contents not cleared.
REQ-028 Reset mid-operation discards all queued bytes; an rx_int fall in the first cycle after reset release does not write (rx_int_q=0).

Configuration
REQ-029 Macro UART_RXF_DROP_OLD_EN undefined: byte arriving while full is discarded; queue unchanged.
REQ-030 Macro UART_RXF_DROP_OLD_EN defined: byte arriving while full overwrites oldest entry; rd_ptr and wr_ptr both advance; fill_cnt stays DEPTH; overflow still set.

Verification
REQ-031 Single frame: rx_data=8'hA5, rx_int 1->0 in cycle N, dout_ready=0 -> cycle N+1 dout_valid=1, dout=8'hA5, fill_cnt=1.
REQ-032 Order/wrap: 40 bytes 8'h00..8'h27, consumer drains between frames -> read sequence 8'h00..8'h27 exact, no overflow.
REQ-033 Fill: 16 bytes 8'h10..8'h1F, no reads -> full=1, fill_cnt=16; 17th byte 8'hEE -> overflow=1; default drain yields 8'h10..8'h1F; DROP_OLD_EN drain yields 8'h11..8'h1F,8'hEE.
REQ-034 Full with simultaneous wr and dout_ready=1 -> fill_cnt stays 16, overflow=0, head advances by one.
REQ-035 ovf_clr pulse with no event -> overflow=0 next cycle; ovf_clr coincident with overflow event -> overflow remains 1.
REQ-036 5 bytes queued, rst_n low one cycle -> dout_valid=0, fill_cnt=0, overflow=0; next byte 8'h3C read back as first entry.
